// File: rtl/cache_line_arbiter_pkg.sv
// Shared types for the I/D cache line-port arbiter: FSM states, grant side and memory op.
package line_arb_types;
   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} arb_state_t;
   typedef enum logic {GRANT_I, GRANT_D} grant_t;
   typedef enum logic {OP_READ, OP_WRITE} mem_op_t;
endpackage

// File: rtl/cache_line_arbiter_grant_sel.sv
// Combinational round-robin picker between I-cache and D-cache requests; zero latency.
// On a tie the side that did not win last time is chosen; no backpressure of its own.
module line_arb_grant_sel
   import line_arb_types::*;
(
   input  logic   i_icache_req,
   input  logic   i_dcache_req,
   input  grant_t i_last_grant,
   output logic   o_grant_vld,
   output grant_t o_grant
);

   always_comb begin
      o_grant_vld = i_icache_req | i_dcache_req;
      o_grant     = GRANT_I;
      if (i_icache_req && i_dcache_req)
         o_grant = (i_last_grant == GRANT_I) ? GRANT_D : GRANT_I;
      else if (i_dcache_req)
         o_grant = GRANT_D;
   end

endmodule

// File: rtl/cache_line_arbiter.sv
// Shares one memory line port between I-cache and D-cache, one transaction at a time.
// Memory request from the cycle after grant; requester resp same cycle as mem_resp; one DONE cycle before next grant.
module cache_line_arbiter
   import line_arb_types::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_pmem_read,
   input  logic [ADDR_WIDTH-1:0] i_pmem_address,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                  i_pmem_resp,
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [ADDR_WIDTH-1:0] d_pmem_address,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  d_pmem_resp,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp
);

   arb_state_t            r_state;
   grant_t                r_last_grant;
   mem_op_t               r_op;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LINE_WIDTH-1:0] r_wdata;

   logic   w_dcache_req;
   logic   w_grant_vld;
   grant_t w_grant;
   logic   w_serving;

   assign w_dcache_req = d_pmem_read | d_pmem_write;

   line_arb_grant_sel u_grant_sel (
      .i_icache_req (i_pmem_read),
      .i_dcache_req (w_dcache_req),
      .i_last_grant (r_last_grant),
      .o_grant_vld  (w_grant_vld),
      .o_grant      (w_grant)
   );

   // Request inputs are sampled only in IDLE; address/data stay frozen until DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_last_grant <= GRANT_I;
         r_op         <= OP_READ;
         r_addr       <= '0;
         r_wdata      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_vld) begin
                  r_last_grant <= w_grant;
                  if (w_grant == GRANT_I) begin
                     r_addr  <= i_pmem_address;
                     r_op    <= OP_READ;
                     r_state <= SERVE_I;
                  end else begin
                     r_addr  <= d_pmem_address;
                     r_wdata <= d_pmem_wdata;
                     r_op    <= d_pmem_write ? OP_WRITE : OP_READ;
                     r_state <= SERVE_D;
                  end
               end
            end
            SERVE_I, SERVE_D: begin
               if (mem_resp)
                  r_state <= DONE;
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_serving    = (r_state == SERVE_I) || (r_state == SERVE_D);
   assign mem_read     = w_serving && (r_op == OP_READ);
   assign mem_write    = w_serving && (r_op == OP_WRITE);
   assign mem_address  = r_addr;
   assign mem_wdata    = r_wdata;

   assign i_pmem_resp  = (r_state == SERVE_I) && mem_resp;
   assign d_pmem_resp  = (r_state == SERVE_D) && mem_resp;
   assign i_pmem_rdata = (r_state == SERVE_I) ? mem_rdata : '0;
   assign d_pmem_rdata = (r_state == SERVE_D) ? mem_rdata : '0;

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Directed self-checking bench for cache_line_arbiter: inputs change on negedge, outputs checked 1ns later.
module tb_cache_line_arbiter;

   localparam int AW = 32;
   localparam int LW = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_pmem_read;
   logic [AW-1:0] i_pmem_address;
   logic [LW-1:0] i_pmem_rdata;
   logic          i_pmem_resp;
   logic          d_pmem_read;
   logic          d_pmem_write;
   logic [AW-1:0] d_pmem_address;
   logic [LW-1:0] d_pmem_wdata;
   logic [LW-1:0] d_pmem_rdata;
   logic          d_pmem_resp;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_address;
   logic [LW-1:0] mem_wdata;
   logic [LW-1:0] mem_rdata;
   logic          mem_resp;

   int checks   = 0;
   int failures = 0;

   logic [LW-1:0] pat_a5;
   logic [LW-1:0] pat_1234;
   logic [LW-1:0] pat_other;
   logic [LW-1:0] pat_k;
   logic [AW-1:0] exp_addr;

   always #5 clk = ~clk;

   cache_line_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_address (i_pmem_address),
      .i_pmem_rdata   (i_pmem_rdata),
      .i_pmem_resp    (i_pmem_resp),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_address (d_pmem_address),
      .d_pmem_wdata   (d_pmem_wdata),
      .d_pmem_rdata   (d_pmem_rdata),
      .d_pmem_resp    (d_pmem_resp),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_address    (mem_address),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_resp       (mem_resp)
   );

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      pat_a5    = {32{8'hA5}};
      pat_1234  = {8{32'h1234_5678}};
      pat_other = {8{32'hDEAD_BEEF}};

      rst = 1'b1;
      i_pmem_read = 1'b0; i_pmem_address = '0;
      d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
      mem_rdata = '0; mem_resp = 1'b0;

      // Reset state
      tick(); tick(); #1;
      chk("rst_mem_read",  LW'(mem_read),  LW'(0));
      chk("rst_mem_write", LW'(mem_write), LW'(0));
      chk("rst_mem_addr",  LW'(mem_address), LW'(0));
      chk("rst_i_resp",    LW'(i_pmem_resp), LW'(0));
      chk("rst_d_rdata",   d_pmem_rdata, LW'(0));
      rst = 1'b0;

      // I-cache read at 0x100, address changed to 0x300 during SERVE_I
      tick();
      i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0100;
      #1 chk("i_idle_no_read", LW'(mem_read), LW'(0));
      tick(); #1;
      chk("i_mem_read",  LW'(mem_read),  LW'(1));
      chk("i_mem_write", LW'(mem_write), LW'(0));
      chk("i_mem_addr",  LW'(mem_address), LW'(32'h100));
      i_pmem_address = 32'h0000_0300;
      for (int c = 2; c < 5; c++) begin
         tick(); #1;
         chk("i_addr_stable", LW'(mem_address), LW'(32'h100));
         chk("i_no_early_resp", LW'(i_pmem_resp), LW'(0));
      end
      tick();
      mem_resp = 1'b1; mem_rdata = pat_a5;
      #1;
      chk("i_resp",       LW'(i_pmem_resp), LW'(1));
      chk("i_rdata",      i_pmem_rdata, pat_a5);
      chk("i_d_resp_off", LW'(d_pmem_resp), LW'(0));
      chk("i_d_rdata_0",  d_pmem_rdata, LW'(0));
      tick();
      mem_resp = 1'b0; i_pmem_read = 1'b0;
      #1;
      chk("i_done_no_read", LW'(mem_read), LW'(0));
      chk("i_done_no_resp", LW'(i_pmem_resp), LW'(0));
      chk("i_done_rdata_0", i_pmem_rdata, LW'(0));
      tick();

      // D-cache writeback at 0x200
      d_pmem_write = 1'b1; d_pmem_address = 32'h0000_0200; d_pmem_wdata = pat_1234;
      tick(); #1;
      chk("d_mem_write", LW'(mem_write), LW'(1));
      chk("d_mem_read",  LW'(mem_read),  LW'(0));
      chk("d_mem_addr",  LW'(mem_address), LW'(32'h200));
      chk("d_mem_wdata", mem_wdata, pat_1234);
      d_pmem_wdata = pat_other;
      tick(); #1;
      chk("d_wdata_stable", mem_wdata, pat_1234);
      chk("d_no_early_resp", LW'(d_pmem_resp), LW'(0));
      mem_resp = 1'b1; mem_rdata = pat_other;
      #1;
      chk("d_resp",      LW'(d_pmem_resp), LW'(1));
      chk("d_i_resp_off", LW'(i_pmem_resp), LW'(0));
      chk("d_i_rdata_0", i_pmem_rdata, LW'(0));
      tick();
      mem_resp = 1'b0; d_pmem_write = 1'b0;
      #1;
      chk("d_resp_one_cycle", LW'(d_pmem_resp), LW'(0));
      chk("d_done_no_write",  LW'(mem_write), LW'(0));
      tick();

      // Reset again so the first tie goes to D, then alternation D,I,D,I
      rst = 1'b1;
      tick();
      rst = 1'b0;
      i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0400;
      d_pmem_read = 1'b1; d_pmem_address = 32'h0000_0500;
      for (int k = 0; k < 4; k++) begin
         exp_addr = (k % 2 == 0) ? 32'h500 : 32'h400;
         pat_k = {8{32'hC0DE_0000 + 32'(k)}};
         tick(); #1;
         chk("tie_grant_addr", LW'(mem_address), LW'(exp_addr));
         chk("tie_mem_read",   LW'(mem_read), LW'(1));
         mem_resp = 1'b1; mem_rdata = pat_k;
         #1;
         chk("tie_d_resp", LW'(d_pmem_resp), LW'(k % 2 == 0));
         chk("tie_i_resp", LW'(i_pmem_resp), LW'(k % 2 == 1));
         chk("tie_rdata", (k % 2 == 0) ? d_pmem_rdata : i_pmem_rdata, pat_k);
         tick();
         mem_resp = 1'b0;
         #1 chk("tie_done_idle", LW'(mem_read), LW'(0));
         tick();
         #1 chk("tie_n2_idle", LW'(mem_read), LW'(0));
      end
      i_pmem_read = 1'b0; d_pmem_read = 1'b0;
      tick(); tick();

      // Read+write together on D: write wins; then reset mid-transaction
      d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 32'h0000_0600; d_pmem_wdata = pat_a5;
      tick(); #1;
      chk("rw_mem_write", LW'(mem_write), LW'(1));
      chk("rw_mem_read",  LW'(mem_read),  LW'(0));
      rst = 1'b1; mem_resp = 1'b1;
      #1;
      chk("rst_async_write", LW'(mem_write), LW'(0));
      chk("rst_no_d_resp",   LW'(d_pmem_resp), LW'(0));
      tick();
      rst = 1'b0; mem_resp = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
      tick();

      // Spurious mem_resp in IDLE
      mem_resp = 1'b1; mem_rdata = pat_a5;
      #1;
      chk("spur_i_resp", LW'(i_pmem_resp), LW'(0));
      chk("spur_d_resp", LW'(d_pmem_resp), LW'(0));
      chk("spur_i_rdata", i_pmem_rdata, LW'(0));
      tick();
      mem_resp = 1'b0;
      #1 chk("spur_still_idle", LW'(mem_read), LW'(0));

      // Normal I read after reset recovery
      i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0700;
      tick(); #1;
      chk("post_mem_read", LW'(mem_read), LW'(1));
      chk("post_mem_addr", LW'(mem_address), LW'(32'h700));
      mem_resp = 1'b1; mem_rdata = pat_1234;
      #1;
      chk("post_i_resp",  LW'(i_pmem_resp), LW'(1));
      chk("post_i_rdata", i_pmem_rdata, pat_1234);
      tick();
      mem_resp = 1'b0; i_pmem_read = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cache_line_arbiter.md
Name: cache_line_arbiter

Overview:
Shares the single physical-memory line port between the instruction-cache miss path and the data-cache miss/writeback path. It sits between the two caches and the cacheline adaptor, below the pipeline's i_mem/d_mem ports. The block serves one line transaction at a time. When both caches request in the same cycle, it grants round-robin and holds the grant until the memory responds.

Parameters:
ADDR_WIDTH, 32, width of line addresses on all ports
LINE_WIDTH, 256, width of one cache line of data

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
i_pmem_read  input  1  I-cache line read request, held until i_pmem_resp
i_pmem_address  input  ADDR_WIDTH  I-cache line address
i_pmem_rdata  output  LINE_WIDTH  line returned to the I-cache
i_pmem_resp  output  1  one-cycle completion pulse to the I-cache
d_pmem_read  input  1  D-cache line read request
d_pmem_write  input  1  D-cache line writeback request
d_pmem_address  input  ADDR_WIDTH  D-cache line address
d_pmem_wdata  input  LINE_WIDTH  D-cache writeback data
d_pmem_rdata  output  LINE_WIDTH  line returned to the D-cache
d_pmem_resp  output  1  one-cycle completion pulse to the D-cache
mem_read  output  1  read request to the cacheline adaptor
mem_write  output  1  write request to the cacheline adaptor
mem_address  output  ADDR_WIDTH  latched address of the granted transaction
mem_wdata  output  LINE_WIDTH  latched writeback data
mem_rdata  input  LINE_WIDTH  line from the adaptor
mem_resp  input  1  completion pulse from the adaptor

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, last_grant=I (so D wins the first tie), address/wdata/op registers = 0.
- Outputs while reset is asserted or while idle: mem_read=0, mem_write=0, both resp=0, both rdata=0.
- States: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE, i request only: latch i_pmem_address and op=read, go to SERVE_I.
- IDLE, d request only: latch d_pmem_address, d_pmem_wdata and op, go to SERVE_D.
- IDLE, both requesting: grant the side not equal to last_grant.
- IDLE, no request: stay in IDLE.
- last_grant updates on every grant.
- D op encoding: d_pmem_write=1 means a write, even if d_pmem_read is also 1 (illegal combination; write wins). Otherwise the op is a read.
- SERVE_x, memory side: mem_read or mem_write is driven from the registered op. mem_address and mem_wdata are driven from the latched registers and stay stable for the whole transaction.
- SERVE_x, completion: on mem_resp=1, x_pmem_resp=1 in the same cycle (combinational), x_pmem_rdata=mem_rdata, then go to DONE.
- rdata of the non-granted side is always 0.
- DONE: lasts one cycle with no memory request, giving the requester a cycle to drop its request. Returns to IDLE.
- Latency: request seen in IDLE at cycle 0 → mem_read/mem_write high from cycle 1 → mem_resp at cycle N → requester resp at cycle N → next grant decided at cycle N+2 at the earliest.
- A requester that drops its request mid-transaction is ignored; the transaction completes and the resp pulse is still issued.
- mem_resp in IDLE or DONE is ignored and produces no requester resp.
- rst asserted mid-transaction: state returns to IDLE immediately and mem_read/mem_write drop asynchronously. The pending requester receives no resp.
- The address of a request is never re-sampled after grant. Changes to the request address during SERVE have no effect.

Decomposition:
- Package line_arb_types holds:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D, DONE}
  - grant_t enum {GRANT_I, GRANT_D}
  - mem_op_t enum {OP_READ, OP_WRITE}
- One sub-module, line_arb_grant_sel, is natural: combinational round-robin picker taking (i_req, d_req, last_grant) and producing (grant_valid, grant).
- The FSM, latch registers and output muxing stay in cache_line_arbiter.

Test Plan:
- I read only, address 0x0000_0100: mem_read=1 from cycle 1 with mem_address=0x100. mem_resp at cycle 5 with mem_rdata=0xA5..A5 → i_pmem_resp=1 and i_pmem_rdata=0xA5..A5 at cycle 5, d_pmem_resp=0 throughout.
- D writeback, address 0x200, wdata=0x1234..: mem_write=1, mem_wdata=0x1234.. stable until mem_resp. d_pmem_resp pulses exactly one cycle.
- I and D requesting together after reset → D granted first. Both held → I granted next (first grant cycle at N+2). Repeat → strictly alternates D, I, D, I.
- d_pmem_read=1 and d_pmem_write=1 together → mem_write=1, mem_read=0.
- Change i_pmem_address from 0x100 to 0x300 during SERVE_I → mem_address stays 0x100.
- Spurious mem_resp in IDLE → no requester resp. rst pulse mid-SERVE_D → mem_write=0 in the same cycle, state IDLE, no d_pmem_resp. After release, a new I request is served normally.
